// File: rtl/frame_aligner_pkg.sv
// Shared constants and types for the frame aligner.
// Header byte values, frame length, FSM state and header type encodings.
package frame_aligner_pkg;

  localparam logic [7:0] HDR1_LSB = 8'hAA;
  localparam logic [7:0] HDR1_MSB = 8'hAF;
  localparam logic [7:0] HDR2_LSB = 8'h55;
  localparam logic [7:0] HDR2_MSB = 8'hBA;

  localparam int unsigned FRAME_LEN = 12;

  typedef enum logic [1:0] {
    HDR_LSB = 2'd0,
    HDR_MSB = 2'd1,
    PAYLOAD = 2'd2
  } fa_state_e;

  typedef enum logic {
    HDR_T1 = 1'b0,
    HDR_T2 = 1'b1
  } hdr_type_e;

  // 3-bit counter increment that sticks at its maximum instead of wrapping
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/fa_hdr_match.sv
// Combinational header byte classifier: detects a header LSB (and its type)
// and checks whether the current byte is the MSB matching a recorded type.
module fa_hdr_match
  import frame_aligner_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] rx_data,
  input  hdr_type_e         rec_type,
  output logic              lsb_hit,
  output hdr_type_e         lsb_type,
  output logic              msb_hit
);

  // classify the byte against both header types
  always_comb begin
    lsb_hit  = 1'b0;
    lsb_type = HDR_T1;
    msb_hit  = 1'b0;
    if (rx_data == HDR1_LSB) begin
      lsb_hit  = 1'b1;
      lsb_type = HDR_T1;
    end else if (rx_data == HDR2_LSB) begin
      lsb_hit  = 1'b1;
      lsb_type = HDR_T2;
    end else begin
      lsb_hit  = 1'b0;
      lsb_type = HDR_T1;
    end
    if (rec_type == HDR_T2) begin
      msb_hit = (rx_data == HDR2_MSB);
    end else begin
      msb_hit = (rx_data == HDR1_MSB);
    end
  end

endmodule

// File: rtl/frame_aligner.sv
// Byte-stream frame aligner: finds 2-byte headers spaced FRAME_LEN bytes apart,
// reports byte position and lock. Optional frame counter: FRAME_ALIGNER_STATS_EN.
module frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PAYLOAD_LEN = 10,
  parameter int LOCK_CNT    = 3,
  parameter int UNLOCK_CNT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  output logic [3:0]        fr_byte_position,
  output logic              frame_detect
`ifdef FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam logic [3:0] LAST_POS  = 4'(PAYLOAD_LEN + 1);
  localparam logic [2:0] LOCK_TH   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_TH = 3'(UNLOCK_CNT);

  fa_state_e  state_r, state_s;
  hdr_type_e  type_r, type_s;
  logic [3:0] pos_r, pos_s;
  logic [2:0] good_r, good_s;
  logic [2:0] bad_r, bad_s;
  logic       lock_r, lock_s;
  logic       lsb_ok_r, lsb_ok_s;
  logic       boundary_r, boundary_s;
`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] cnt_r, cnt_s;
`endif

  logic      lsb_hit;
  hdr_type_e lsb_type;
  logic      msb_hit;

  fa_hdr_match #(.DATA_W(DATA_W)) u_match (
    .rx_data  (rx_data),
    .rec_type (type_r),
    .lsb_hit  (lsb_hit),
    .lsb_type (lsb_type),
    .msb_hit  (msb_hit)
  );

  // next-state: search/acquire when unlocked, flywheel through fixed slots when locked
  always_comb begin
    state_s    = state_r;
    type_s     = type_r;
    pos_s      = pos_r;
    good_s     = good_r;
    bad_s      = bad_r;
    lock_s     = lock_r;
    lsb_ok_s   = lsb_ok_r;
    boundary_s = 1'b0;
`ifdef FRAME_ALIGNER_STATS_EN
    cnt_s      = cnt_r;
`endif
    case (state_r)
      HDR_LSB: begin
        pos_s = 4'd0;
        if (lock_r) begin
          state_s  = HDR_MSB;
          lsb_ok_s = lsb_hit;
          type_s   = lsb_type;
        end else if (lsb_hit) begin
          state_s  = HDR_MSB;
          lsb_ok_s = 1'b1;
          type_s   = lsb_type;
        end else begin
          state_s  = HDR_LSB;
          lsb_ok_s = 1'b0;
          // a missing header where one was due breaks the good run
          if (boundary_r) begin
            good_s = 3'd0;
          end else begin
            good_s = good_r;
          end
        end
      end
      HDR_MSB: begin
        if (lock_r) begin
          pos_s   = 4'd1;
          state_s = PAYLOAD;
          if (lsb_ok_r && msb_hit) begin
            bad_s = 3'd0;
`ifdef FRAME_ALIGNER_STATS_EN
            cnt_s = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
`endif
          end else if (sat_inc3(bad_r) >= UNLOCK_TH) begin
            lock_s   = 1'b0;
            good_s   = 3'd0;
            bad_s    = 3'd0;
            pos_s    = 4'd0;
            state_s  = HDR_LSB;
            lsb_ok_s = 1'b0;
`ifdef FRAME_ALIGNER_STATS_EN
            cnt_s    = 16'd0;
`endif
          end else begin
            bad_s = sat_inc3(bad_r);
          end
        end else if (msb_hit) begin
          pos_s   = 4'd1;
          state_s = PAYLOAD;
          good_s  = sat_inc3(good_r);
          if (sat_inc3(good_r) >= LOCK_TH) begin
            lock_s = 1'b1;
          end else begin
            lock_s = 1'b0;
          end
        end else begin
          good_s = 3'd0;
          pos_s  = 4'd0;
          // the failing byte may itself start a new header
          if (lsb_hit) begin
            state_s  = HDR_MSB;
            type_s   = lsb_type;
            lsb_ok_s = 1'b1;
          end else begin
            state_s  = HDR_LSB;
            lsb_ok_s = 1'b0;
          end
        end
      end
      PAYLOAD: begin
        pos_s = pos_r + 4'd1;
        if (pos_r == LAST_POS - 4'd1) begin
          state_s    = HDR_LSB;
          boundary_s = 1'b1;
        end else begin
          state_s = PAYLOAD;
        end
      end
      default: begin
        state_s  = HDR_LSB;
        pos_s    = 4'd0;
        lsb_ok_s = 1'b0;
      end
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= HDR_LSB;
      type_r     <= HDR_T1;
      pos_r      <= 4'd0;
      good_r     <= 3'd0;
      bad_r      <= 3'd0;
      lock_r     <= 1'b0;
      lsb_ok_r   <= 1'b0;
      boundary_r <= 1'b0;
`ifdef FRAME_ALIGNER_STATS_EN
      cnt_r      <= 16'd0;
`endif
    end else begin
      state_r    <= state_s;
      type_r     <= type_s;
      pos_r      <= pos_s;
      good_r     <= good_s;
      bad_r      <= bad_s;
      lock_r     <= lock_s;
      lsb_ok_r   <= lsb_ok_s;
      boundary_r <= boundary_s;
`ifdef FRAME_ALIGNER_STATS_EN
      cnt_r      <= cnt_s;
`endif
    end
  end

  assign fr_byte_position = pos_r;
  assign frame_detect     = lock_r;
`ifdef FRAME_ALIGNER_STATS_EN
  assign frame_cnt        = cnt_r;
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// Self-checking bench for frame_aligner: slot-based reference model, directed
// scenarios with literal pins, then a randomized byte stream.
module tb_frame_aligner;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic [3:0] pos;
  logic       det;
`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] fcnt;
`endif

  frame_aligner dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .fr_byte_position (pos),
    .frame_detect     (det)
`ifdef FRAME_ALIGNER_STATS_EN
    ,
    .frame_cnt        (fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // reference model: slot of the next byte within the frame, -1 while searching
  int         m_slot;
  logic [7:0] m_prev;
  int         m_good, m_bad, m_cnt;
  bit         m_lock;
  logic [3:0] exp_pos;
  bit         exp_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_lsb(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'h55);
  endfunction

  function automatic bit is_pair(input logic [7:0] p, input logic [7:0] b);
    return ((p == 8'hAA) && (b == 8'hAF)) || ((p == 8'h55) && (b == 8'hBA));
  endfunction

  task automatic model_reset();
    m_slot = -1; m_prev = 8'h00; m_good = 0; m_bad = 0; m_cnt = 0; m_lock = 1'b0;
    exp_pos = 4'd0; exp_lock = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] b);
    int p;
    p = 0;
    if (m_lock) begin
      p = m_slot;
      if (m_slot == 1) begin
        if (is_pair(m_prev, b)) begin
          m_bad = 0;
          if (m_cnt < 65535) m_cnt++;
          m_slot = 2;
        end else begin
          m_bad++;
          if (m_bad >= 4) begin
            m_lock = 1'b0; m_good = 0; m_bad = 0; m_cnt = 0; p = 0; m_slot = -1;
          end else begin
            m_slot = 2;
          end
        end
      end else begin
        m_slot = (m_slot + 1) % 12;
      end
    end else begin
      case (m_slot)
        -1: begin
          p = 0;
          if (is_lsb(b)) m_slot = 1;
        end
        0: begin
          p = 0;
          if (is_lsb(b)) m_slot = 1;
          else begin m_good = 0; m_slot = -1; end
        end
        1: begin
          if (is_pair(m_prev, b)) begin
            p = 1; m_slot = 2;
            if (m_good < 7) m_good++;
            if (m_good >= 3) m_lock = 1'b1;
          end else begin
            p = 0; m_good = 0;
            m_slot = is_lsb(b) ? 1 : -1;
          end
        end
        default: begin
          p = m_slot;
          m_slot = (m_slot + 1) % 12;
        end
      endcase
    end
    m_prev   = b;
    exp_pos  = p[3:0];
    exp_lock = m_lock;
  endtask

  // every cycle: registered outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pos", {28'd0, pos}, {28'd0, exp_pos});
      check("lock", {31'd0, det}, {31'd0, exp_lock});
`ifdef FRAME_ALIGNER_STATS_EN
      check("frame_cnt", {16'd0, fcnt}, m_cnt);
`endif
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    reset   = 1'b1;
    rx_data = b;
    model_step(b);
    chk_en  = 1'b1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      reset   = 1'b0;
      rx_data = 8'($urandom);
      model_reset();
      chk_en  = 1'b1;
    end
  endtask

  // literal expectation right after the last driven byte has been sampled
  task automatic pin(input string name, input logic [3:0] p, input logic d);
    @(posedge clk); #2;
    check({name, "_pos"}, {28'd0, pos}, {28'd0, p});
    check({name, "_lock"}, {31'd0, det}, {31'd0, d});
  endtask

  function automatic logic [7:0] clean_byte();
    logic [7:0] b;
    b = 8'($urandom);
    while (is_lsb(b)) b = 8'($urandom);
    return b;
  endfunction

  task automatic send_payload(input int n, input bit clean);
    for (int i = 0; i < n; i++) send(clean ? clean_byte() : 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] m);
    send(l); send(m); send_payload(10, 1'b1);
  endtask

  initial begin
    reset   = 1'b0;
    rx_data = 8'h00;
    model_reset();

    do_reset(3);
    pin("reset", 4'd0, 1'b0);

    // three back-to-back type-1 frames
    send(8'hAA); send(8'hAF); pin("f1_hdr", 4'd1, 1'b0);
    send_payload(10, 1'b1); pin("f1_end", 4'd11, 1'b0);
    send_frame(8'hAA, 8'hAF);
    send(8'hAA); pin("f3_lsb", 4'd0, 1'b0);
    send(8'hAF); pin("f3_msb", 4'd1, 1'b1);
    send_payload(10, 1'b1);

    // alternating header types
    do_reset(1);
    send_frame(8'h55, 8'hBA);
    send_frame(8'hAA, 8'hAF);
    send(8'h55); send(8'hBA); pin("alt_lock", 4'd1, 1'b1);
    send_payload(10, 1'b1);

    // broken header restarts the good run
    do_reset(1);
    send_frame(8'hAA, 8'hAF);
    send_frame(8'hAA, 8'hAF);
    send(8'hAA); send(8'h00); pin("break", 4'd0, 1'b0);
    send_payload(10, 1'b1);
    send_frame(8'hAA, 8'hAF);
    send(8'hAA); send(8'hAF); pin("after_break2", 4'd1, 1'b0);
    send_payload(10, 1'b1);
    send(8'h55); send(8'hBA); pin("after_break3", 4'd1, 1'b1);
    send_payload(10, 1'b1);

    // flywheel: 3 bad then good keeps lock; 4 bad drops it
    for (int i = 0; i < 3; i++) send_frame(8'h11, 8'h22);
    send(8'hAA); send(8'hAF); pin("fly_good", 4'd1, 1'b1);
    send_payload(10, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'hAA, 8'hBA);
    send(8'h55); send(8'hAF); pin("unlock", 4'd0, 1'b0);
    send_payload(10, 1'b1);

    // reset mid-payload while locked
    for (int i = 0; i < 3; i++) send_frame(8'hAA, 8'hAF);
    send(8'hAA); send(8'hAF); send_payload(5, 1'b1); pin("mid_pos6", 4'd6, 1'b1);
    do_reset(1); pin("mid_reset", 4'd0, 1'b0);
    send_frame(8'h55, 8'hBA);
    send_frame(8'h55, 8'hBA);
    send(8'hAA); send(8'hAF); pin("relock", 4'd1, 1'b1);
    send_payload(10, 1'b1);

    // randomized stream
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 11) begin
        if ($urandom_range(0, 1) == 0) begin send(8'hAA); send(8'hAF); end
        else begin send(8'h55); send(8'hBA); end
        send_payload(10, 1'b0);
      end else if (r < 14) begin
        case ($urandom_range(0, 3))
          0: begin send(8'hAA); send(8'hBA); end
          1: begin send(8'h55); send(8'hAF); end
          2: begin send(8'hAA); send(8'h55); end
          default: begin send(8'($urandom)); send(8'($urandom)); end
        endcase
        send_payload(10, 1'b0);
      end else if (r < 17) begin
        send_payload($urandom_range(1, 5), 1'b0);
      end else if (r < 19) begin
        send(($urandom_range(0, 1) == 0) ? 8'hAA : 8'h55);
      end else begin
        do_reset(1);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
